// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two Avalon-MM masters.
// One access per cycle, read data one cycle after grant; losers see waitrequest and hold.
module onchip_mem_arbiter #(
    parameter int ADDR_W    = 18,
    parameter int DATA_W    = 16,
    parameter int BE_W      = 2,
    parameter int NUM_WORDS = 133081
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              oor_err
);

    localparam logic [ADDR_W:0] WORD_LIMIT = (ADDR_W+1)'(NUM_WORDS);

    logic              req0, req1;
    logic              grant0, grant1, grant_any;
    logic              granted_is_write;
    logic              in_range;
    logic              prio;
    logic              rd_valid, rd_owner, rd_oor;
    logic [DATA_W-1:0] readdata;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Reset forces grant to none so nothing reaches the RAM while held in reset.
    assign grant0    = reset_n & req0 & (~req1 | ~prio);
    assign grant1    = reset_n & req1 & (~req0 | prio);
    assign grant_any = grant0 | grant1;

    assign m0_waitrequest = ~grant0;
    assign m1_waitrequest = ~grant1;

    assign mem_address      = grant1 ? m1_address    : m0_address;
    assign mem_byteenable   = grant1 ? m1_byteenable : m0_byteenable;
    assign mem_writedata    = grant1 ? m1_writedata  : m0_writedata;
    assign granted_is_write = grant1 ? m1_write      : m0_write;

    assign in_range       = {1'b0, mem_address} < WORD_LIMIT;
    assign mem_chipselect = grant_any & in_range;
    assign mem_write      = mem_chipselect & granted_is_write;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio     <= 1'b0;
            rd_valid <= 1'b0;
            rd_owner <= 1'b0;
            rd_oor   <= 1'b0;
            oor_err  <= 1'b0;
        end else begin
            if (grant_any) begin
                prio <= grant0;
            end
            rd_valid <= grant_any & ~granted_is_write;
            rd_owner <= grant1;
            rd_oor   <= ~in_range;
            oor_err  <= grant_any & ~in_range;
        end
    end

    assign readdata         = rd_oor ? '0 : mem_readdata;
    assign m0_readdata      = readdata;
    assign m1_readdata      = readdata;
    assign m0_readdatavalid = rd_valid & ~rd_owner;
    assign m1_readdatavalid = rd_valid & rd_owner;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Randomized and directed bench with a shadow-memory scoreboard for onchip_mem_arbiter.
module tb_onchip_mem_arbiter;

    localparam int NUM_WORDS = 133081;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [17:0] m0_address, m1_address;
    logic [1:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [15:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [15:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [17:0] mem_address;
    logic [1:0]  mem_byteenable;
    logic        mem_chipselect, mem_write;
    logic [15:0] mem_writedata;
    logic [15:0] mem_readdata = 16'h0;
    logic        oor_err;

    onchip_mem_arbiter #(.NUM_WORDS(NUM_WORDS)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .oor_err(oor_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [15:0] ram    [int unsigned];
    logic [15:0] shadow [int unsigned];

    // RAM slave: registered read, byte-lane write.
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                logic [15:0] w;
                w = ram.exists(mem_address) ? ram[mem_address] : 16'h0;
                if (mem_byteenable[0]) w[7:0]  = mem_writedata[7:0];
                if (mem_byteenable[1]) w[15:8] = mem_writedata[15:8];
                ram[mem_address] = w;
            end else begin
                mem_readdata <= ram.exists(mem_address) ? ram[mem_address] : 16'h0;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] shadow_rd(input logic [17:0] a);
        return shadow.exists(a) ? shadow[a] : 16'h0;
    endfunction

    task automatic preload(input logic [17:0] a, input logic [15:0] d);
        ram[a]    = d;
        shadow[a] = d;
    endtask

    // ---------------- reference model / monitor ----------------
    logic [15:0] q0[$], q1[$];
    int          model_prio = 0;
    logic        exp_oor = 1'b0;
    logic [15:0] last_rd0 = 16'h0;
    int          oor_cnt = 0;
    int          vld_cnt0 = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_wait0", m0_waitrequest, 1);
            chk("rst_wait1", m1_waitrequest, 1);
            chk("rst_cs", mem_chipselect, 0);
            chk("rst_we", mem_write, 0);
            chk("rst_vld", {m1_readdatavalid, m0_readdatavalid}, 0);
            chk("rst_oor", oor_err, 0);
            q0.delete();
            q1.delete();
            model_prio = 0;
            exp_oor = 1'b0;
        end else begin
            bit r0, r1;
            int winner;
            r0 = m0_read | m0_write;
            r1 = m1_read | m1_write;
            if (r0 && r1)  winner = model_prio;
            else if (r0)   winner = 0;
            else if (r1)   winner = 1;
            else           winner = -1;

            chk("wait0", m0_waitrequest, (winner == 0) ? 0 : 1);
            chk("wait1", m1_waitrequest, (winner == 1) ? 0 : 1);

            if (q0.size() > 0) begin
                chk("vld0", m0_readdatavalid, 1);
                chk("rdata0", m0_readdata, q0[0]);
                void'(q0.pop_front());
            end else begin
                chk("vld0_idle", m0_readdatavalid, 0);
            end
            if (q1.size() > 0) begin
                chk("vld1", m1_readdatavalid, 1);
                chk("rdata1", m1_readdata, q1[0]);
                void'(q1.pop_front());
            end else begin
                chk("vld1_idle", m1_readdatavalid, 0);
            end
            if (m0_readdatavalid) begin
                last_rd0 = m0_readdata;
                vld_cnt0++;
            end
            chk("oor_err", oor_err, exp_oor);
            if (oor_err) oor_cnt++;

            if (winner >= 0) begin
                logic [17:0] a;
                logic [1:0]  be;
                logic [15:0] d;
                bit          wr, inr;
                a  = (winner == 1) ? m1_address    : m0_address;
                be = (winner == 1) ? m1_byteenable : m0_byteenable;
                d  = (winner == 1) ? m1_writedata  : m0_writedata;
                wr = (winner == 1) ? m1_write      : m0_write;
                inr = (int'(a) < NUM_WORDS);
                chk("mem_addr", mem_address, a);
                chk("mem_cs", mem_chipselect, inr);
                chk("mem_we", mem_write, inr && wr);
                if (wr) begin
                    if (inr) begin
                        logic [15:0] w;
                        w = shadow_rd(a);
                        if (be[0]) w[7:0]  = d[7:0];
                        if (be[1]) w[15:8] = d[15:8];
                        shadow[a] = w;
                        chk("mem_wdata", mem_writedata, d);
                        chk("mem_be", mem_byteenable, be);
                    end
                end else if (winner == 0) begin
                    q0.push_back(inr ? shadow_rd(a) : 16'h0);
                end else begin
                    q1.push_back(inr ? shadow_rd(a) : 16'h0);
                end
                exp_oor = !inr;
                model_prio = 1 - winner;
            end else begin
                chk("idle_cs", mem_chipselect, 0);
                chk("idle_addr", mem_address, m0_address);
                exp_oor = 1'b0;
            end
        end
    end

    // ---------------- master drivers ----------------
    task automatic drive(input int m, input bit rd, input bit wr, input logic [17:0] a,
                         input logic [1:0] be, input logic [15:0] d);
        if (m == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
        end
    endtask

    // Entered and left at posedge+1; holds the request until accepted.
    task automatic issue(input int m, input bit rd, input bit wr, input logic [17:0] a,
                         input logic [1:0] be, input logic [15:0] d);
        bit done;
        done = 0;
        drive(m, rd, wr, a, be, d);
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (((m == 0) ? m0_waitrequest : m1_waitrequest) == 1'b0) done = 1;
            @(posedge clk); #1;
        end
        if (!done) chk("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int m, input int n);
        drive(m, 0, 0, 18'h0, 2'b11, 16'h0);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic rand_master(input int m, input int n);
        logic [17:0] a;
        int unsigned r;
        bit          wr, rd;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 99);
            if (r < 8)        a = 18'(NUM_WORDS + $urandom_range(0, 5));
            else if (r < 10)  a = 18'h3FFFF;
            else if (r < 12)  a = 18'(NUM_WORDS - 1);
            else              a = 18'($urandom_range(0, 15));
            wr = 1'($urandom_range(0, 1));
            rd = wr ? ($urandom_range(0, 3) == 0) : 1'b1;
            issue(m, rd, wr, a, 2'($urandom_range(0, 3)), 16'($urandom));
            if ($urandom_range(0, 3) == 0) idle(m, $urandom_range(1, 3));
        end
        idle(m, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int v0;
        reset_n = 1'b0;
        drive(0, 1, 0, 18'h10, 2'b11, 16'h0);
        drive(1, 1, 0, 18'h20, 2'b11, 16'h0);
        preload(18'h10, 16'h1111);
        preload(18'h20, 16'h2222);
        preload(18'h100, 16'h1234);
        preload(18'(NUM_WORDS - 1), 16'h5A5A);
        for (int i = 0; i < 8; i++) preload(18'(i), 16'($urandom));
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("first_grant_m0", m0_waitrequest, 0);
        chk("first_grant_m1_waits", m1_waitrequest, 1);
        @(posedge clk); #1;

        // Contention: both masters read continuously.
        fork
            for (int i = 0; i < 6; i++) issue(0, 1, 0, 18'h10, 2'b11, 16'h0);
            for (int i = 0; i < 6; i++) issue(1, 1, 0, 18'h20, 2'b11, 16'h0);
        join
        idle(0, 0);
        idle(1, 2);

        // Single master streaming.
        c0 = cyc;
        for (int i = 0; i < 8; i++) issue(1, 1, 0, 18'(i), 2'b11, 16'h0);
        chk("stream_cycles", cyc - c0, 8);
        drive(0, 1, 0, 18'h3, 2'b11, 16'h0);
        drive(1, 1, 0, 18'h4, 2'b11, 16'h0);
        @(negedge clk);
        chk("prio_after_stream_m0", m0_waitrequest, 0);
        chk("prio_after_stream_m1", m1_waitrequest, 1);
        @(posedge clk); #1;
        idle(0, 0);
        issue(1, 1, 0, 18'h4, 2'b11, 16'h0);
        idle(1, 2);

        // Byte-lane write then read.
        issue(0, 0, 1, 18'h100, 2'b10, 16'hABCD);
        issue(0, 1, 0, 18'h100, 2'b11, 16'h0);
        idle(0, 2);
        chk("byte_lane_read", last_rd0, 16'hAB34);

        // Out of range write then read.
        last_rd0 = 16'hDEAD;
        oor_cnt = 0;
        issue(0, 0, 1, 18'(NUM_WORDS), 2'b11, 16'hFFFF);
        issue(0, 1, 0, 18'(NUM_WORDS), 2'b11, 16'h0);
        idle(0, 3);
        chk("oor_pulses", oor_cnt, 2);
        chk("oor_read_zero", last_rd0, 16'h0);
        issue(0, 1, 0, 18'(NUM_WORDS - 1), 2'b11, 16'h0);
        idle(0, 2);
        chk("last_word_read", last_rd0, 16'h5A5A);

        // Reset while a read is in flight.
        v0 = vld_cnt0;
        issue(0, 1, 0, 18'h5, 2'b11, 16'h0);
        reset_n = 1'b0;
        drive(0, 0, 0, 18'h0, 2'b11, 16'h0);
        repeat (3) begin @(posedge clk); #1; end
        reset_n = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        chk("no_valid_after_reset", vld_cnt0, v0);

        // Randomized traffic from both masters.
        for (int i = 0; i < 16; i++) preload(18'(i), 16'($urandom));
        fork
            rand_master(0, 150);
            rand_master(1, 150);
        join
        repeat (3) begin @(posedge clk); #1; end
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/onchip_mem_arbiter.md
# onchip_mem_arbiter

Two-master round-robin arbiter that shares the single-port 16-bit on-chip RAM (18-bit word address, 2-bit byte enable, unregistered output, 1-cycle read latency) between two Avalon-MM masters. It sits between the masters' interconnect ports and the RAM slave. It grants at most one access per cycle, returns read data with `readdatavalid` tagging, and blocks out-of-range accesses.

## Interface
- `ADDR_W`, default 18: word address width.
- `DATA_W`, default 16: data width.
- `BE_W`, default 2: byte-enable width (`DATA_W/8`).
- `NUM_WORDS`, default 133081: valid depth. Addresses `>= NUM_WORDS` are out of range.

Ports:
- `clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `mN_address`  in  ADDR_W  master N word address (N = 0, 1).
- `mN_byteenable`  in  BE_W  master N byte lanes.
- `mN_read`  in  1  master N read request.
- `mN_write`  in  1  master N write request.
- `mN_writedata`  in  DATA_W  master N write data.
- `mN_waitrequest`  out  1  high = request not accepted this cycle.
- `mN_readdata`  out  DATA_W  read data to master N.
- `mN_readdatavalid`  out  1  one-cycle pulse marking valid `mN_readdata`.
- `mem_address`  out  ADDR_W  to RAM.
- `mem_byteenable`  out  BE_W  to RAM.
- `mem_chipselect`  out  1  to RAM.
- `mem_write`  out  1  to RAM.
- `mem_writedata`  out  DATA_W  to RAM.
- `mem_readdata`  in  DATA_W  from RAM, valid the cycle after the address is presented.
- `oor_err`  out  1  registered one-cycle pulse: an out-of-range access was accepted in the previous cycle.

## Operation
- **Request.** `reqN = mN_read | mN_write`. If both are high, the request is a write and the read is ignored.
- **Grant.** Grant is combinational from `req0`, `req1` and the registered pointer `prio` (0 or 1).
  - If only one master requests, it is granted.
  - If both request, master `prio` is granted.
  - After any grant, `prio` becomes the other master.
  - With no requests, `prio` holds.
- **Waitrequest.** `mN_waitrequest = ~grantN`, including idle cycles. Ungranted masters hold their request (Avalon rule). The arbiter does not store requests.
- **Memory mux.** `mem_address`, `mem_byteenable` and `mem_writedata` follow the granted master. With no grant they follow master 0.
  - `mem_chipselect = grant_any & in_range`.
  - `mem_write = mem_chipselect & granted_is_write`.
- **Read return.** On a granted read, the block registers `rd_valid = 1`, `rd_owner = N` and `rd_oor`.
  - Next cycle: `m<rd_owner>_readdatavalid = 1`.
  - `readdata = rd_oor ? 0 : mem_readdata`.
  - Both `mN_readdata` ports carry the same muxed value. Only the owner's valid is asserted.
- **Out of range.**
  - Write: accepted (waitrequest low), RAM untouched.
  - Read: accepted, returns `0x0000` with normal valid timing.
  - Either case: `oor_err` pulses the following cycle.
- **State.** `prio`, `rd_valid`, `rd_owner`, `rd_oor`, `oor_err`. No FSM beyond these registers.

## Timing
- **Reset values** (asynchronous, `reset_n = 0`):
  - `prio = 0`, `rd_valid = 0`, `oor_err = 0`.
  - All `mN_readdatavalid = 0`.
  - During reset, grant is forced to none: `mN_waitrequest = 1`, `mem_chipselect = 0`, `mem_write = 0`.
  - `mN_readdata` = mux of `mem_readdata` (don't care).
- **Accept.** Accept in cycle T means waitrequest is low in T. The write is committed at the T→T+1 clock edge.
- **Read latency.** Exactly 1 cycle: grant in T gives `readdatavalid` in T+1.
- **Throughput.** 1 access per cycle total. Back-to-back reads from one or both masters pipeline without bubbles.
- **Contention.** Continuous contention alternates grants 0,1,0,1… starting from `prio`. Worst-case wait per master is 1 cycle.
- **Write then read, same address.** The read is granted the cycle after the write and returns the new data. Same-cycle write/read is impossible (single grant).
- **Reset mid-operation.** An in-flight read's `readdatavalid` is suppressed, and no valid is emitted after reset release. After release, the first grant follows `prio = 0`.

## Test plan
- **Reset.** Assert `reset_n = 0` with both masters requesting → both waitrequests = 1, `mem_chipselect = 0`. Release → master 0 is granted first.
- **Contention.** Both masters read continuously, m0 at 0x00010, m1 at 0x00020, RAM preloaded 0x1111/0x2222 → grants alternate every cycle, and the valids alternate m0/m1 one cycle later with the correct data.
- **Single master streaming.** m1 reads addresses 0..7 back-to-back while m0 is idle → `m1_waitrequest` stays low for 8 cycles, 8 consecutive valids arrive with the correct data, and `prio` ends at 0.
- **Byte-lane write.** m0 writes 0xABCD to 0x00100 with `byteenable = 2'b10` over the old value 0x1234 → a following read returns 0xAB34, valid exactly 1 cycle after its grant.
- **Out of range.** m0 writes 0xFFFF to address 133081, then reads it → `mem_chipselect = 0` on both accesses, `oor_err` pulses twice, and the read returns 0x0000 with `readdatavalid`.
- **Reset during read.** m0 is granted a read in T and `reset_n` drops in T+1 before the clock edge → `m0_readdatavalid` stays 0, and no stray valid appears after release.
